// File: rtl/uart_tx_serializer.sv
`default_nettype none
// =============================================================================
// uart_tx_serializer: UART frame transmitter (start, LSB-first data, parity, stop)
// Rev 1.0
// =============================================================================
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 input_clock,
  input  logic                 input_reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_wrap;
  logic                 parity_bit;

  assign baud_wrap  = (baud_q == BAUD_LAST);
  assign parity_bit = (PARITY_ODD != 0) ? ~^data_q : ^data_q;

  // Every output is computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          data_d   = tx_data;
          shift_d  = tx_data;
          state_d  = S_START;
          baud_d   = '0;
          bit_d    = '0;
          serial_d = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          state_d  = S_DATA;
          baud_d   = '0;
          serial_d = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d  = S_PARITY;
              serial_d = parity_bit;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 1'b1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          state_d  = S_STOP;
          baud_d   = '0;
          bit_d    = '0;
          serial_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d  = S_IDLE;
            bit_d    = '0;
            serial_d = 1'b1;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        baud_d   = '0;
        bit_d    = '0;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_ready  = ready_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule
`default_nettype wire
